// File: rtl/csa_resolve.sv
// Sequential carry-propagate adder that resolves a carry-save (sum, carry) pair into binary,
// CHUNK_LEN bits per cycle, with the inter-chunk carry held in a register.
module csa_resolve #(
  parameter int unsigned BIT_LEN   = 381,
  parameter int unsigned CHUNK_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] sum_in,
  input  logic [BIT_LEN-1:0] carry_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN:0]   result
);

  localparam int unsigned NUM_CHUNKS = (BIT_LEN + CHUNK_LEN - 1) / CHUNK_LEN;
  localparam int unsigned PAD_LEN    = NUM_CHUNKS * CHUNK_LEN;
  // Width of the final (possibly narrow) chunk; its carry-out lands at this bit of the chunk sum.
  localparam int unsigned LAST_W     = BIT_LEN - (NUM_CHUNKS - 1) * CHUNK_LEN;
  localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [PAD_LEN-1:0] a_q, a_d;
  logic [PAD_LEN-1:0] b_q, b_d;
  logic               c_q, c_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BIT_LEN-1:0] res_q, res_d;
  logic               cout_q, cout_d;
  logic [CHUNK_LEN:0] chunk_sum;

  // Operands are shifted down each cycle, so the active chunk is always the low slice.
  // Padding above BIT_LEN is zero, so the narrow last chunk cannot pick up stray carries.
  always_comb begin
    chunk_sum = {1'b0, a_q[CHUNK_LEN-1:0]} + {1'b0, b_q[CHUNK_LEN-1:0]}
              + (CHUNK_LEN + 1)'(c_q);
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    idx_d       = idx_q;
    res_d       = res_q;
    cout_d      = cout_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d        = PAD_LEN'(sum_in);
          b_d        = PAD_LEN'(carry_in);
          c_d        = 1'b0;
          idx_d      = '0;
          state_d    = StBusy;
          in_ready_d = 1'b0;
        end
      end
      StBusy: begin
        for (int unsigned i = 0; i < BIT_LEN; i++) begin
          if (IDX_W'(i / CHUNK_LEN) == idx_q) begin
            res_d[i] = chunk_sum[i % CHUNK_LEN];
          end
        end
        a_d = a_q >> CHUNK_LEN;
        b_d = b_q >> CHUNK_LEN;
        c_d = chunk_sum[CHUNK_LEN];
        if (idx_q == LAST_IDX) begin
          cout_d      = chunk_sum[LAST_W];
          state_d     = StDone;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      idx_q       <= '0;
      res_q       <= '0;
      cout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      idx_q       <= idx_d;
      res_q       <= res_d;
      cout_q      <= cout_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = {cout_q, res_q};

endmodule
